// File: rtl/i2s_tx_ctrl_if.sv
// Handshake bundle between the DSP sample streams, control, and the i2sm_tx
// sample request port. The slave side is i2s_tx_ctrl.
interface i2s_tx_ctrl_if #(
    parameter int DW = 24
);
    logic          l_valid;
    logic          l_ready;
    logic [DW-1:0] l_sample;
    logic          r_valid;
    logic          r_ready;
    logic [DW-1:0] r_sample;
    logic          start;
    logic          stop;
    logic          mute;
    logic          tx_en;
    logic          tx_rd_en;
    logic          tx_valid;
    logic [DW-1:0] tx_sample;
    logic          busy;
    logic [15:0]   underrun_ct;

    modport master (
        output l_valid, l_sample, r_valid, r_sample, start, stop, mute, tx_rd_en,
        input  l_ready, r_ready, tx_en, tx_valid, tx_sample, busy, underrun_ct
    );

    modport slave (
        input  l_valid, l_sample, r_valid, r_sample, start, stop, mute, tx_rd_en,
        output l_ready, r_ready, tx_en, tx_valid, tx_sample, busy, underrun_ct
    );
endinterface

// File: rtl/i2s_tx_ctrl.sv
// Stereo sample scheduler for i2sm_tx: per-channel FIFOs, prefill/run/drain
// sequencing and strict L/R request alternation with underrun counting.
module i2s_tx_ctrl_fifo #(
    parameter int DW    = 24,
    parameter int DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_valid,
    input  logic [DW-1:0]            i_data,
    input  logic                     i_pop,
    output logic                     o_ready,
    output logic [DW-1:0]            o_data,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic          r_ready;
    logic          w_push;
    logic          w_pop;
    logic [LW-1:0] w_level_nxt;

    assign w_push      = i_valid && r_ready;
    assign w_pop       = i_pop && (r_level != '0);
    assign w_level_nxt = r_level + LW'(w_push) - LW'(w_pop);

    // Ready is a flop of the next level so a same-cycle pop never opens it early.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ready  <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_level <= w_level_nxt;
            r_ready <= (w_level_nxt != LW'(DEPTH));
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_ready = r_ready;
    assign o_data  = r_mem[r_rd_ptr];
    assign o_level = r_level;
    assign o_empty = (r_level == '0);
endmodule

module i2s_tx_ctrl #(
    parameter int DW      = 24,
    parameter int DEPTH   = 8,
    parameter int PREFILL = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    i2s_tx_ctrl_if.slave bus
);
    localparam int LW  = $clog2(DEPTH) + 1;
    localparam int NCH = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PREFILL,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic                     r_ptr;
    logic                     r_tx_valid;
    logic [DW-1:0]            r_tx_sample;
    logic [15:0]              r_underrun_ct;

    logic [NCH-1:0]           w_push_vld;
    logic [NCH-1:0]           w_ready;
    logic [NCH-1:0]           w_pop;
    logic [NCH-1:0]           w_empty;
    logic [NCH-1:0][DW-1:0]   w_wdata;
    logic [NCH-1:0][DW-1:0]   w_rdata;
    logic [NCH-1:0][LW-1:0]   w_level;
    logic                     w_req;
    logic                     w_cur_empty;
    logic                     w_prefill_ok;

    assign w_push_vld = {bus.r_valid, bus.l_valid};
    assign w_wdata    = {bus.r_sample, bus.l_sample};

    // Channel 0 is left, channel 1 is right; r_ptr indexes them directly.
    generate
        for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
            i2s_tx_ctrl_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
                .i_clk   (i_clk),
                .i_rst   (i_rst),
                .i_valid (w_push_vld[ch]),
                .i_data  (w_wdata[ch]),
                .i_pop   (w_pop[ch]),
                .o_ready (w_ready[ch]),
                .o_data  (w_rdata[ch]),
                .o_level (w_level[ch]),
                .o_empty (w_empty[ch])
            );
        end
    endgenerate

    assign w_req        = bus.tx_rd_en && ((r_state == S_RUN) || (r_state == S_DRAIN));
    assign w_cur_empty  = w_empty[r_ptr];
    assign w_prefill_ok = (w_level[0] >= LW'(PREFILL)) && (w_level[1] >= LW'(PREFILL));

    always_comb begin
        w_pop = '0;
        if (w_req && !w_cur_empty) w_pop[r_ptr] = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (bus.start) w_state_nxt = S_PREFILL;
            S_PREFILL: begin
                if (bus.stop)          w_state_nxt = S_IDLE;
                else if (w_prefill_ok) w_state_nxt = S_RUN;
            end
            S_RUN:     if (bus.stop) w_state_nxt = S_DRAIN;
            S_DRAIN:   if (w_req && r_ptr) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr         <= 1'b0;
            r_tx_valid    <= 1'b0;
            r_tx_sample   <= '0;
            r_underrun_ct <= '0;
        end else begin
            r_tx_valid <= w_req;
            if (r_state == S_PREFILL && w_state_nxt == S_RUN) r_ptr <= 1'b0;
            else if (w_req)                                   r_ptr <= ~r_ptr;
            // Mute still pops so the L/R pairing survives the muted span.
            if (w_req) r_tx_sample <= (bus.mute || w_cur_empty) ? '0 : w_rdata[r_ptr];
            if (r_state == S_IDLE && bus.start)
                r_underrun_ct <= '0;
            else if (w_req && w_cur_empty && r_underrun_ct != 16'hFFFF)
                r_underrun_ct <= r_underrun_ct + 16'd1;
        end
    end

    assign bus.l_ready     = w_ready[0];
    assign bus.r_ready     = w_ready[1];
    assign bus.tx_en       = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign bus.tx_valid    = r_tx_valid;
    assign bus.tx_sample   = r_tx_sample;
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.underrun_ct = r_underrun_ct;
endmodule

// File: tb/tb_i2s_tx_ctrl.sv
// Directed plus randomized bench for i2s_tx_ctrl against a queue-based
// behavioural model of the scheduler.
module tb_i2s_tx_ctrl;
    localparam int DW      = 24;
    localparam int DEPTH   = 8;
    localparam int PREFILL = 4;

    localparam int M_IDLE  = 0;
    localparam int M_PRE   = 1;
    localparam int M_RUN   = 2;
    localparam int M_DRAIN = 3;

    logic clk = 1'b0;
    logic rst;

    i2s_tx_ctrl_if #(.DW(DW)) bus ();

    i2s_tx_ctrl #(.DW(DW), .DEPTH(DEPTH), .PREFILL(PREFILL)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    logic [DW-1:0] lq [$];
    logic [DW-1:0] rq [$];
    int            m_mode = M_IDLE;
    bit            m_ch   = 1'b0;
    logic [15:0]   m_ct   = '0;
    logic [DW-1:0] m_samp = '0;
    bit            m_valid = 1'b0;
    bit            m_rdy_l = 1'b0;
    bit            m_rdy_r = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model across the edge, compare after it.
    task automatic step(input bit lv, input logic [DW-1:0] ld, input bit rv, input logic [DW-1:0] rdat,
                        input bit st, input bit sp, input bit mu, input bit rq_in, input bit rs);
        int            ln;
        int            rn;
        bit            served;
        bit            was_r;
        logic [DW-1:0] v;
        rst          = rs;
        bus.l_valid  = lv;
        bus.l_sample = ld;
        bus.r_valid  = rv;
        bus.r_sample = rdat;
        bus.start    = st;
        bus.stop     = sp;
        bus.mute     = mu;
        bus.tx_rd_en = rq_in;
        if (rs) begin
            lq.delete();
            rq.delete();
            m_mode  = M_IDLE;
            m_ch    = 1'b0;
            m_ct    = '0;
            m_samp  = '0;
            m_valid = 1'b0;
            m_rdy_l = 1'b0;
            m_rdy_r = 1'b0;
        end else begin
            ln      = lq.size();
            rn      = rq.size();
            served  = rq_in && (m_mode == M_RUN || m_mode == M_DRAIN);
            was_r   = m_ch;
            m_valid = served;
            if (served) begin
                if ((!m_ch && ln > 0) || (m_ch && rn > 0)) begin
                    v      = m_ch ? rq.pop_front() : lq.pop_front();
                    m_samp = mu ? '0 : v;
                end else begin
                    m_samp = '0;
                    if (m_ct != 16'hFFFF) m_ct++;
                end
                m_ch = !m_ch;
            end
            if (lv && m_rdy_l) lq.push_back(ld);
            if (rv && m_rdy_r) rq.push_back(rdat);
            case (m_mode)
                M_IDLE: if (st) begin m_mode = M_PRE; m_ct = '0; end
                M_PRE: begin
                    if (sp) m_mode = M_IDLE;
                    else if (ln >= PREFILL && rn >= PREFILL) begin m_mode = M_RUN; m_ch = 1'b0; end
                end
                M_RUN:   if (sp) m_mode = M_DRAIN;
                default: if (served && was_r) m_mode = M_IDLE;
            endcase
            m_rdy_l = (lq.size() != DEPTH);
            m_rdy_r = (rq.size() != DEPTH);
        end
        @(posedge clk);
        #1;
        chk("tx_en",       32'(bus.tx_en),       32'(m_mode == M_RUN || m_mode == M_DRAIN));
        chk("busy",        32'(bus.busy),        32'(m_mode != M_IDLE));
        chk("tx_valid",    32'(bus.tx_valid),    32'(m_valid));
        chk("tx_sample",   32'(bus.tx_sample),   32'(m_samp));
        chk("underrun_ct", 32'(bus.underrun_ct), 32'(m_ct));
        chk("l_ready",     32'(bus.l_ready),     32'(m_rdy_l));
        chk("r_ready",     32'(bus.r_ready),     32'(m_rdy_r));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0, '0, 0, 0, 0, 0, 0);
    endtask

    task automatic req(input bit mu);
        step(0, '0, 0, '0, 0, 0, mu, 1, 0);
    endtask

    task automatic push_rand(input int nl, input int nr);
        for (int i = 0; i < nl || i < nr; i++)
            step(i < nl, DW'($urandom), i < nr, DW'($urandom), 0, 0, 0, 0, 0);
    endtask

    initial begin
        // Reset and the basic prefill/run sequence with known samples.
        step(0, '0, 0, '0, 0, 0, 0, 0, 1);
        step(0, '0, 0, '0, 0, 0, 0, 0, 1);
        idle(2);
        for (int i = 1; i <= 4; i++) step(1, DW'(i), 1, DW'(24'h100000 + i), 0, 0, 0, 0, 0);
        step(0, '0, 0, '0, 1, 0, 0, 0, 0);
        idle(3);
        for (int i = 0; i < 8; i++) begin
            req(0);
            idle(63);
        end

        // Both FIFOs empty: requests underrun and return 0.
        for (int i = 0; i < 4; i++) begin
            req(0);
            idle(2);
        end

        // Stop right after an L response: the R request finishes the frame.
        req(0);
        step(0, '0, 0, '0, 0, 1, 0, 0, 0);
        idle(2);
        req(0);
        idle(3);
        for (int i = 0; i < 3; i++) req(0);
        idle(2);

        // Prefill met on L only, then L overfilled, then the last R entry arrives.
        push_rand(4, 3);
        step(0, '0, 0, '0, 1, 0, 0, 0, 0);
        idle(5);
        push_rand(4, 0);
        step(1, DW'($urandom), 0, '0, 0, 0, 0, 0, 0);
        idle(1);
        push_rand(0, 1);
        idle(3);

        // One muted frame, then unmuted samples continue in order.
        req(1);
        idle(1);
        req(1);
        idle(2);
        for (int i = 0; i < 4; i++) begin
            req(0);
            idle(1);
        end

        // Random traffic, control pulses and mute.
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 1) == 1, DW'($urandom), $urandom_range(0, 1) == 1, DW'($urandom),
                 $urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 2) == 0, 0);

        // Reset in the middle of RUN with 3 entries left in each FIFO.
        step(0, '0, 0, '0, 0, 0, 0, 0, 1);
        idle(1);
        push_rand(4, 4);
        step(0, '0, 0, '0, 1, 0, 0, 0, 0);
        idle(3);
        req(0);
        req(0);
        step(0, '0, 0, '0, 0, 0, 0, 0, 1);
        idle(2);
        step(0, '0, 0, '0, 1, 0, 0, 0, 0);
        idle(2);
        req(0);
        req(0);
        push_rand(4, 4);
        idle(3);
        req(0);
        req(0);

        // Back-to-back requests long enough to saturate the underrun counter.
        for (int i = 0; i < 65560; i++) req(0);
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
